// File: rtl/plane_hit_detector.sv
// Bullet vs enemy-plane collision scanner: snapshots the playfield on start, walks one plane
// slot per cycle, and reports the first overlapping enabled plane as a one-hot destroy pulse.
module plane_hit_detector #(
    parameter int unsigned N_PLANES   = 10,
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned PLANE_SIZE = 5,
    parameter int unsigned BULLET_W   = 1,
    parameter int unsigned BULLET_H   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          bullet_valid,
    input  logic [COORD_W-1:0]            bullet_x,
    input  logic [COORD_W-1:0]            bullet_y,
    input  logic [N_PLANES*COORD_W-1:0]   plane_x,
    input  logic [N_PLANES*COORD_W-1:0]   plane_y,
    input  logic [N_PLANES-1:0]           plane_en,
    output logic                          busy,
    output logic                          done,
    output logic                          hit,
    output logic [N_PLANES-1:0]           destroyed,
    output logic [3:0]                    hit_index,
    output logic [7:0]                    score
);

    // One extra bit so box edges near the right/bottom border never wrap.
    localparam int unsigned    ExtW    = COORD_W + 1;
    localparam logic [ExtW-1:0] BwM1   = ExtW'(BULLET_W - 1);
    localparam logic [ExtW-1:0] BhM1   = ExtW'(BULLET_H - 1);
    localparam logic [ExtW-1:0] PsM1   = ExtW'(PLANE_SIZE - 1);
    localparam logic [3:0]      LastIdx = 4'(N_PLANES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StReport
    } state_e;

    state_e state_q, state_d;

    logic [COORD_W-1:0]          bx_q, by_q;
    logic [N_PLANES*COORD_W-1:0] px_q, py_q;
    logic [N_PLANES-1:0]         en_q;
    logic [3:0]                  idx_q;

    logic                        busy_q, done_q, hit_q;
    logic [N_PLANES-1:0]         destroyed_q;
    logic [3:0]                  hit_index_q;
    logic [7:0]                  score_q;

    logic [COORD_W-1:0]          cur_px, cur_py;
    logic                        cur_en;
    logic [N_PLANES-1:0]         slot_sel;
    logic [ExtW-1:0]             bx_e, by_e, px_e, py_e;
    logic                        overlap;
    logic                        accept;
    logic                        scan_last;

    // Slot mux driven by the scan index; slot_sel doubles as the one-hot destroy pattern.
    always_comb begin
        cur_px   = '0;
        cur_py   = '0;
        cur_en   = 1'b0;
        slot_sel = '0;
        for (int unsigned i = 0; i < N_PLANES; i++) begin
            if (idx_q == 4'(i)) begin
                cur_px      = px_q[i*COORD_W +: COORD_W];
                cur_py      = py_q[i*COORD_W +: COORD_W];
                cur_en      = en_q[i];
                slot_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        bx_e    = {1'b0, bx_q};
        by_e    = {1'b0, by_q};
        px_e    = {1'b0, cur_px};
        py_e    = {1'b0, cur_py};
        overlap = cur_en
                  && (bx_e + BwM1 >= px_e)
                  && (bx_e <= px_e + PsM1)
                  && (by_e + BhM1 >= py_e)
                  && (by_e <= py_e + PsM1);
    end

    assign scan_last = (idx_q == LastIdx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && bullet_valid) begin
                    state_d = StScan;
                    accept  = 1'b1;
                end
            end
            StScan: begin
                if (overlap || scan_last) begin
                    state_d = StReport;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q        <= '0;
            by_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            en_q        <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            destroyed_q <= '0;
            hit_index_q <= '0;
            score_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            destroyed_q <= '0;
            if (accept) begin
                bx_q   <= bullet_x;
                by_q   <= bullet_y;
                px_q   <= plane_x;
                py_q   <= plane_y;
                en_q   <= plane_en;
                idx_q  <= '0;
                busy_q <= 1'b1;
            end
            if (state_q == StScan) begin
                if (overlap) begin
                    // idx_q is left on the hit slot so REPORT can latch it.
                    done_q      <= 1'b1;
                    hit_q       <= 1'b1;
                    destroyed_q <= slot_sel;
                end else if (scan_last) begin
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
            end
            if (state_q == StReport) begin
                busy_q <= 1'b0;
                if (hit_q) begin
                    hit_index_q <= idx_q;
                    if (score_q != 8'hFF) begin
                        score_q <= score_q + 8'd1;
                    end
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign destroyed = destroyed_q;
    assign hit_index = hit_index_q;
    assign score     = score_q;

endmodule

// File: tb/tb_plane_hit_detector.sv
// Bench for plane_hit_detector: directed vector table, hand sequences for multi-cycle corners,
// and randomized scans checked against a pixel-level overlap model.
module tb_plane_hit_detector;

    localparam int NP = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              bullet_valid;
    logic [7:0]        bullet_x, bullet_y;
    logic [NP*8-1:0]   plane_x, plane_y;
    logic [NP-1:0]     plane_en;
    logic              busy, done, hit;
    logic [NP-1:0]     destroyed;
    logic [3:0]        hit_index;
    logic [7:0]        score;

    plane_hit_detector dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bullet_valid (bullet_valid),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .plane_x      (plane_x),
        .plane_y      (plane_y),
        .plane_en     (plane_en),
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .destroyed    (destroyed),
        .hit_index    (hit_index),
        .score        (score)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_score = 0;
    int exp_hidx = 0;
    int tbx, tby;
    int tpx[NP];
    int tpy[NP];
    logic [NP-1:0] ten;

    typedef struct packed {
        logic [7:0] bx, by;
        logic [3:0] sa;
        logic [7:0] ax, ay;
        logic [3:0] sb;
        logic [7:0] cx, cy;
        logic [9:0] en;
        logic       ehit;
        logic [3:0] eidx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_planes();
        for (int i = 0; i < NP; i++) begin
            tpx[i] = 200;
            tpy[i] = 200;
        end
        ten = '0;
    endtask

    task automatic apply_inputs();
        bullet_x = 8'(tbx);
        bullet_y = 8'(tby);
        for (int i = 0; i < NP; i++) begin
            plane_x[i*8 +: 8] = 8'(tpx[i]);
            plane_y[i*8 +: 8] = 8'(tpy[i]);
        end
        plane_en = ten;
    endtask

    // Reference: does any bullet pixel fall inside the plane's 5x5 pixel square? No wrap.
    task automatic model(output logic mh, output int mi);
        mh = 1'b0;
        mi = 0;
        for (int i = 0; i < NP; i++) begin
            if (!mh && ten[i]) begin
                for (int dy = 0; dy < 3; dy++) begin
                    for (int dx = 0; dx < 1; dx++) begin
                        if (tbx + dx >= tpx[i] && tbx + dx < tpx[i] + 5 &&
                            tby + dy >= tpy[i] && tby + dy < tpy[i] + 5) begin
                            mh = 1'b1;
                            mi = i;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_scan(input logic eh, input int ei, input bit mutate, input string tag);
        int   k;
        bit   seen;
        bit   quiet_ok;
        logic [31:0] ev;
        apply_inputs();
        bullet_valid = 1'b1;
        start        = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        seen     = 1'b0;
        quiet_ok = 1'b1;
        for (k = 1; k <= 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy || hit || destroyed != '0) quiet_ok = 1'b0;
            if (mutate && k == 2) begin
                // Every live plane now sits on the bullet and a new start is requested.
                for (int i = 0; i < NP; i++) begin
                    tpx[i] = tbx;
                    tpy[i] = tby;
                end
                ten = '1;
                apply_inputs();
                start = 1'b1;
            end
            if (mutate && k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: no done within 20 cycles, expected at cycle %0d",
                     tag, eh ? 2 + ei : NP + 1);
            return;
        end
        ev = eh ? (32'd1 << ei) : 32'd0;
        chk({tag, " scan-phase busy/quiet"}, 32'(quiet_ok), 32'd1);
        chk({tag, " done cycle"}, k, eh ? 2 + ei : NP + 1);
        chk({tag, " hit"}, 32'(hit), 32'(eh));
        chk({tag, " destroyed"}, 32'(destroyed), ev);
        chk({tag, " busy in report"}, 32'(busy), 32'd1);
        if (eh) begin
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            exp_hidx  = ei;
        end
        @(posedge clk); #1;
        chk({tag, " done width"}, 32'(done), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " destroyed after"}, 32'(destroyed), 32'd0);
        chk({tag, " score"}, 32'(score), 32'(exp_score));
        chk({tag, " hit_index"}, 32'(hit_index), 32'(exp_hidx));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mh;
        int   mi;
        int   cnt;
        reset        = 1'b1;
        start        = 1'b0;
        bullet_valid = 1'b0;
        tbx = 0;
        tby = 0;
        clear_planes();
        apply_inputs();

        vecs[0] = '{8'd10,  8'd10,  4'd0, 8'd8,   8'd8,   4'd0, 8'd8,  8'd8,  10'h001, 1'b1, 4'd0};
        vecs[1] = '{8'd50,  8'd40,  4'd3, 8'd48,  8'd38,  4'd7, 8'd49, 8'd39, 10'h088, 1'b1, 4'd3};
        vecs[2] = '{8'd12,  8'd0,   4'd2, 8'd8,   8'd2,   4'd2, 8'd8,  8'd2,  10'h004, 1'b1, 4'd2};
        vecs[3] = '{8'd12,  8'd0,   4'd2, 8'd7,   8'd2,   4'd2, 8'd7,  8'd2,  10'h004, 1'b0, 4'd0};
        vecs[4] = '{8'd12,  8'd0,   4'd2, 8'd8,   8'd3,   4'd2, 8'd8,  8'd3,  10'h004, 1'b0, 4'd0};
        vecs[5] = '{8'd255, 8'd253, 4'd5, 8'd253, 8'd251, 4'd5, 8'd253, 8'd251, 10'h020, 1'b1, 4'd5};
        vecs[6] = '{8'd255, 8'd253, 4'd5, 8'd0,   8'd0,   4'd5, 8'd0,  8'd0,  10'h020, 1'b0, 4'd0};
        vecs[7] = '{8'd10,  8'd10,  4'd4, 8'd8,   8'd8,   4'd4, 8'd8,  8'd8,  10'h3EF, 1'b0, 4'd0};
        vecs[8] = '{8'd0,   8'd0,   4'd9, 8'd0,   8'd0,   4'd9, 8'd0,  8'd0,  10'h200, 1'b1, 4'd9};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hit", 32'(hit), 32'd0);
        chk("reset destroyed", 32'(destroyed), 32'd0);
        chk("reset hit_index", 32'(hit_index), 32'd0);
        chk("reset score", 32'(score), 32'd0);

        for (int v = 0; v < 9; v++) begin
            clear_planes();
            tbx = int'(vecs[v].bx);
            tby = int'(vecs[v].by);
            tpx[vecs[v].sa] = int'(vecs[v].ax);
            tpy[vecs[v].sa] = int'(vecs[v].ay);
            tpx[vecs[v].sb] = int'(vecs[v].cx);
            tpy[vecs[v].sb] = int'(vecs[v].cy);
            ten = vecs[v].en;
            run_scan(vecs[v].ehit, int'(vecs[v].eidx), 1'b0, $sformatf("vec%0d", v));
        end

        // start without a bullet in flight is ignored.
        clear_planes();
        tbx = 10; tby = 10; tpx[0] = 8; tpy[0] = 8; ten = 10'h001;
        apply_inputs();
        bullet_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            if (busy || done) cnt++;
            @(posedge clk); #1;
        end
        chk("no-valid activity", 32'(cnt), 32'd0);

        // Mid-scan input changes and a start pulse must not disturb the snapshot.
        clear_planes();
        tbx = 30; tby = 30; tpx[6] = 28; tpy[6] = 29; ten = 10'h040;
        run_scan(1'b1, 6, 1'b1, "snapshot-hit");
        clear_planes();
        tbx = 30; tby = 30; ten = 10'h3FF;
        run_scan(1'b0, 0, 1'b1, "snapshot-miss");

        for (int r = 0; r < 40; r++) begin
            clear_planes();
            tbx = int'($urandom_range(0, 255));
            tby = int'($urandom_range(0, 255));
            for (int i = 0; i < NP; i++) begin
                tpx[i] = (tbx + int'($urandom_range(0, 14)) + 249) % 256;
                tpy[i] = (tby + int'($urandom_range(0, 14)) + 249) % 256;
            end
            ten = NP'($urandom);
            model(mh, mi);
            run_scan(mh, mi, 1'b0, $sformatf("rand%0d", r));
        end

        // Saturation: 255 back-to-back slot-0 hits from a clean score.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_score = 0;
        exp_hidx  = 0;
        clear_planes();
        tbx = 10; tby = 10; tpx[0] = 8; tpy[0] = 8; ten = 10'h001;
        apply_inputs();
        bullet_valid = 1'b1;
        for (int h = 0; h < 255; h++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        exp_score = 255;
        chk("score after 255 hits", 32'(score), 32'd255);
        run_scan(1'b1, 0, 1'b0, "hit256");

        // Reset during cycle 3 of a scan that would hit slot 5 in cycle 7.
        clear_planes();
        tbx = 10; tby = 10; tpx[5] = 8; tpy[5] = 8; ten = 10'h020;
        apply_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort score", 32'(score), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort destroyed", 32'(destroyed), 32'd0);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || destroyed != '0 || busy) cnt++;
            @(posedge clk); #1;
        end
        chk("abort no pulse", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
